// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter (IDLE/ISSUE/WAIT/DONE), round-robin by default
// Define MEM_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins arbitration.
module mem_port_arbiter #(
   parameter int NUM_CORES = 4,
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 16,
   parameter int MEM_LAT   = 2
) (
   input  logic                        Clock,
   input  logic                        Reset_n,
   input  logic [2*NUM_CORES-1:0]      core_memcontrol,
   input  logic [ADDR_W*NUM_CORES-1:0] core_addr,
   input  logic [DATA_W*NUM_CORES-1:0] core_wdata,
   output logic [DATA_W-1:0]           core_rdata,
   output logic [NUM_CORES-1:0]        core_done,
   output logic [NUM_CORES-1:0]        core_stall,
   output logic [1:0]                  mem_ctrl,
   output logic [ADDR_W-1:0]           mem_addr,
   output logic [DATA_W-1:0]           mem_wdata,
   input  logic [DATA_W-1:0]           mem_rdata,
   output logic [3:0]                  grant_id
);

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t              state_q, state_d;
   logic [1:0]          cmd_q, cmd_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic [3:0]          grant_q, grant_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
   logic [3:0]          last_q, last_d;
`endif

   logic [NUM_CORES-1:0] pending;
   logic                 any_pending;
   logic [3:0]           win;
   logic [1:0]           sel_cmd;
   logic [ADDR_W-1:0]    sel_addr;
   logic [DATA_W-1:0]    sel_wdata;

   // 01 and 10 are the only real commands; 00 and 11 both read as idle.
   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         pending[i] = core_memcontrol[2*i] ^ core_memcontrol[2*i+1];
      end
   end

`ifdef MEM_ARB_FIXED_PRIORITY_EN
   always_comb begin
      any_pending = 1'b0;
      win         = '0;
      for (int i = NUM_CORES-1; i >= 0; i--) begin
         if (pending[i]) begin
            any_pending = 1'b1;
            win         = 4'(i);
         end
      end
   end
`else
   // Prefer the lowest pending index above last_grant, else wrap to the lowest overall.
   logic       hi_found;
   logic [3:0] win_hi;
   logic [3:0] win_all;
   always_comb begin
      any_pending = 1'b0;
      hi_found    = 1'b0;
      win_hi      = '0;
      win_all     = '0;
      for (int i = NUM_CORES-1; i >= 0; i--) begin
         if (pending[i]) begin
            any_pending = 1'b1;
            win_all     = 4'(i);
            if (4'(i) > last_q) begin
               hi_found = 1'b1;
               win_hi   = 4'(i);
            end
         end
      end
      win = hi_found ? win_hi : win_all;
   end
`endif

   always_comb begin
      sel_cmd   = '0;
      sel_addr  = '0;
      sel_wdata = '0;
      for (int i = 0; i < NUM_CORES; i++) begin
         if (win == 4'(i)) begin
            sel_cmd   = core_memcontrol[2*i +: 2];
            sel_addr  = core_addr[i*ADDR_W +: ADDR_W];
            sel_wdata = core_wdata[i*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         cmd_q   <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
         last_q  <= 4'(NUM_CORES-1);
`endif
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
         last_q  <= last_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
      last_d  = last_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_pending) begin
               state_d = ISSUE;
               cmd_d   = sel_cmd;
               addr_d  = sel_addr;
               wdata_d = sel_wdata;
               grant_d = win;
`ifndef MEM_ARB_FIXED_PRIORITY_EN
               last_d  = win;
`endif
            end
         end
         ISSUE: begin
            if (cmd_q == 2'b01) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(MEM_LAT-1);
            end else begin
               state_d = DONE;
            end
         end
         WAIT: begin
            // Counter reaching zero lines up with mem_rdata being valid this cycle.
            if (cnt_q == '0) begin
               state_d = DONE;
               rdata_d = mem_rdata;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign mem_ctrl   = (state_q == ISSUE) ? cmd_q   : 2'b00;
   assign mem_addr   = (state_q == ISSUE) ? addr_q  : '0;
   assign mem_wdata  = (state_q == ISSUE) ? wdata_q : '0;
   assign core_rdata = rdata_q;
   assign grant_id   = grant_q;

   always_comb begin
      for (int i = 0; i < NUM_CORES; i++) begin
         core_done[i] = (state_q == DONE) && (grant_q == 4'(i));
      end
   end

   assign core_stall = pending & ~core_done;

endmodule
